event_packer: RTL and testbench
===============================

Name: event_packer

Overview:
- Multi-channel, parametrised successor to the single-channel trigger/sample-to-FIFO path of the muon DAQ top level.
- Each f125_clk cycle it takes one deserialised sample word per channel and continuously holds a pre-trigger history.
- On an accepted trigger it emits a framed event into the external 64-bit FIFO write port: header, timestamp, pre+post data words, trailer.
- Adds channel masking, command-driven arm/disarm, dead-time/overflow accounting and a checksum.

Parameters:
- CH_COUNT, 4: number of input channels, 1..4.
- SAMPLE_W, 16: bits per channel per cycle. CH_COUNT*SAMPLE_W must be <= 64; checked at elaboration.
- PRE_SAMPLES, 8: data words taken before the trigger cycle, 1..255.
- POST_SAMPLES, 24: data words taken from the trigger cycle onward, 1..1023.
- TS_W, 48: free-running timestamp width, <= 64.

Ports:
- f125_clk  in  1  sole clock.
- aresetn  in  1  asynchronous, active-low reset.
- trigger  in  1  synchronous trigger; its rising edge is detected internally.
- ch_data_i  in  CH_COUNT*SAMPLE_W  channel samples; channel c occupies bits [c*SAMPLE_W +: SAMPLE_W].
- cmd_valid_i  in  1  strobe qualifying cmd.
- cmd  in  8  command byte.
- full_i  in  1  external FIFO full.
- wr_en_o  out  1  FIFO write strobe.
- din_o  out  64  FIFO write data.
- event_count_o  out  32  completed events.
- drop_count_o  out  16  rejected triggers, saturating.
- armed_o  out  1  block is armed.
- busy_o  out  1  event in progress.

Behaviour:
- Reset: all outputs 0. State IDLE. Mask = all CH_COUNT bits set. Timestamp = 0. Delay line cleared.
- Reset mid-event aborts the event immediately. No trailer is written.
- Commands, acted on only when cmd_valid_i=1:
  - 0x01 ARM.
  - 0x02 DISARM.
  - 0x03 CLEAR: event_count_o, drop_count_o and timestamp go to 0 on the next edge.
  - 0x1m SET_MASK: mask = m[CH_COUNT-1:0]. Accepted only in IDLE; ignored otherwise.
  - Any other code is ignored.
- Timestamp increments every cycle and wraps modulo 2^TS_W.
- Delay line: always shifting, depth PRE_SAMPLES+3. The data word is the masked, zero-extended ch_data_i; masked channels read as 0.
- States: IDLE, ARMED, HEADER, TSTAMP, DATA, TRAILER.
  - IDLE -> ARMED on ARM.
  - ARMED -> IDLE on DISARM.
  - ARMED -> HEADER on a trigger edge at cycle T with full_i=0. The timestamp and event_id (= event_count_o) are latched at T.
  - HEADER -> TSTAMP -> DATA. DATA runs PRE_SAMPLES+POST_SAMPLES cycles, then -> TRAILER.
  - TRAILER -> ARMED once the trailer is written, or -> IDLE if DISARM was received during the event (disarm is deferred).
- Timing, with wr_en_o registered:
  - Header at T+1: {8'hA5, 4'h0, mask(4), 16'(PRE+POST), event_id[31:0]}.
  - Timestamp word at T+2: zero-extended latched timestamp.
  - Data word k at T+3+k equals the sample presented at cycle T-PRE_SAMPLES+k, for k = 0..PRE+POST-1.
  - Trailer: {8'h5A, 7'h0, ovf, 16'written_data_words, 32'xor}. xor is the XOR of upper and lower halves across all written data words.
- Backpressure:
  - Header, timestamp and data words due while full_i=1 are dropped (wr_en_o=0) and set ovf. Data streaming never stalls.
  - TRAILER waits while full_i=1, then writes the trailer.
  - event_count_o increments on the trailer write.
- Rejections: a trigger edge in ARMED with full_i=1, or in HEADER..TRAILER, is rejected.
  - drop_count_o increments and saturates at 16'hFFFF.
  - Trigger edges in IDLE are ignored and not counted.
- Simultaneous CLEAR and increment: CLEAR wins.
- armed_o = 1 in ARMED..TRAILER unless a disarm is pending.
- busy_o = 1 in HEADER..TRAILER.

Decomposition:
- muon_daq_pkg holds:
  - state enum;
  - cmd opcodes CMD_ARM / CMD_DISARM / CMD_CLEAR / CMD_MASK;
  - HDR_MAGIC 8'hA5 and TRL_MAGIC 8'h5A.
- One sub-module, sample_delay_line: parametrised width/depth shift register with asynchronous active-low reset.

Test Plan:
- ARM, ch_data_i = cycle counter, trigger at counter=100 (PRE=8, POST=24) -> 35 writes: header with event_id=0 and len=32; data words 92..123; trailer with ovf=0, count=32, correct xor; event_count_o=1.
- full_i high for 3 data cycles -> 3 data words missing, trailer ovf=1 and count=29. With full_i still high at the trailer, the trailer is held until full_i drops.
- Second trigger edge 5 cycles after the first -> no new header, drop_count_o=1. A trigger after the trailer -> header with event_id=1.
- ARMED with full_i=1 and a trigger -> no write, drop_count_o=1. Then CLEAR -> drop_count_o=0 and event_count_o=0.
- SET_MASK 0x15 in IDLE, ARM, trigger -> channels 1 and 3 read 0 in data words; header mask=4'h5. SET_MASK sent while busy -> mask unchanged.
- aresetn low at data word 10 -> wr_en_o=0 and din_o=0 immediately; after release, state IDLE with no trailer. DISARM mid-event -> event completes, then armed_o=0.

Source files
------------

// File: rtl/muon_daq_pkg.sv
// muon_daq_pkg: shared FSM states, command opcodes and frame markers for the event packer
package muon_daq_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, HEADER, TSTAMP, DATA, TRAILER} state_t;
  localparam logic [7:0] CMD_ARM    = 8'h01;
  localparam logic [7:0] CMD_DISARM = 8'h02;
  localparam logic [7:0] CMD_CLEAR  = 8'h03;
  localparam logic [3:0] CMD_MASK   = 4'h1;
  localparam logic [7:0] HDR_MAGIC  = 8'hA5;
  localparam logic [7:0] TRL_MAGIC  = 8'h5A;
endpackage

// File: rtl/sample_delay_line.sv
// sample_delay_line: free-running shift register holding the pre-trigger sample history
module sample_delay_line #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/event_packer.sv
// event_packer: frames triggered multi-channel sample windows into a 64-bit FIFO stream
module event_packer
  import muon_daq_pkg::*;
#(
  parameter int CH_COUNT     = 4,
  parameter int SAMPLE_W     = 16,
  parameter int PRE_SAMPLES  = 8,
  parameter int POST_SAMPLES = 24,
  parameter int TS_W         = 48
) (
  input  logic                         f125_clk,
  input  logic                         aresetn,
  input  logic                         trigger,
  input  logic [CH_COUNT*SAMPLE_W-1:0] ch_data_i,
  input  logic                         cmd_valid_i,
  input  logic [7:0]                   cmd,
  input  logic                         full_i,
  output logic                         wr_en_o,
  output logic [63:0]                  din_o,
  output logic [31:0]                  event_count_o,
  output logic [15:0]                  drop_count_o,
  output logic                         armed_o,
  output logic                         busy_o
);
  localparam logic [15:0] N_WORDS = 16'(PRE_SAMPLES + POST_SAMPLES);
  if (CH_COUNT < 1 || CH_COUNT > 4 || CH_COUNT*SAMPLE_W > 64 || PRE_SAMPLES < 1 ||
      PRE_SAMPLES > 255 || POST_SAMPLES < 1 || POST_SAMPLES > 1023 || TS_W < 1 || TS_W > 64)
  begin : g_param_check
    $error("event_packer: unsupported parameter set");
  end
  state_t              state;
  logic [CH_COUNT-1:0] mask;
  logic [TS_W-1:0]     ts, ts_lat;
  logic                trig_d, pend, ovf;
  logic [15:0]         idx, n_wr;
  logic [31:0]         xsum;
  logic [63:0]         masked, dl_out;
  logic                trig_edge, c_arm, c_disarm, c_clear, c_mask, take, reject, leave_idle;
  assign trig_edge  = trigger & ~trig_d;
  assign c_arm      = cmd_valid_i && cmd == CMD_ARM;
  assign c_disarm   = cmd_valid_i && cmd == CMD_DISARM;
  assign c_clear    = cmd_valid_i && cmd == CMD_CLEAR;
  assign c_mask     = cmd_valid_i && cmd[7:4] == CMD_MASK;
  assign busy_o     = state != IDLE && state != ARMED;
  assign armed_o    = state != IDLE && !pend;
  assign take       = state == TSTAMP || (state == DATA && idx != N_WORDS - 16'd1);
  assign reject     = trig_edge && (busy_o || (state == ARMED && full_i && !c_disarm));
  assign leave_idle = (pend | c_disarm) & ~c_arm;
  always_comb begin
    masked = '0;
    for (int c = 0; c < CH_COUNT; c++)
      masked[c*SAMPLE_W +: SAMPLE_W] = mask[c] ? ch_data_i[c*SAMPLE_W +: SAMPLE_W] : '0;
  end
  // The output register is the last stage: a sample reaches din_o PRE_SAMPLES+3 cycles later.
  sample_delay_line #(.W(64), .DEPTH(PRE_SAMPLES + 2)) u_delay (
    .clk  (f125_clk),
    .rst_n(aresetn),
    .d    (masked),
    .q    (dl_out)
  );
  always_ff @(posedge f125_clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      mask          <= '1;
      ts            <= '0;
      ts_lat        <= '0;
      trig_d        <= 1'b0;
      pend          <= 1'b0;
      ovf           <= 1'b0;
      idx           <= '0;
      n_wr          <= '0;
      xsum          <= '0;
      wr_en_o       <= 1'b0;
      din_o         <= '0;
      event_count_o <= '0;
      drop_count_o  <= '0;
    end else begin
      trig_d  <= trigger;
      ts      <= ts + TS_W'(1);
      wr_en_o <= 1'b0;
      if (take) begin
        if (full_i) ovf <= 1'b1;
        else begin
          wr_en_o <= 1'b1;
          din_o   <= dl_out;
          n_wr    <= n_wr + 16'd1;
          xsum    <= xsum ^ dl_out[63:32] ^ dl_out[31:0];
        end
      end
      if (reject && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
      if (busy_o) pend <= leave_idle;
      case (state)
        IDLE: begin
          if (c_mask) mask <= cmd[CH_COUNT-1:0];
          if (c_arm) state <= ARMED;
        end
        ARMED:
          if (c_disarm) state <= IDLE;
          else if (trig_edge && !full_i) begin
            state   <= HEADER;
            wr_en_o <= 1'b1;
            din_o   <= {HDR_MAGIC, 4'h0, 4'(mask), N_WORDS, event_count_o};
            ts_lat  <= ts;
            ovf     <= 1'b0;
            n_wr    <= '0;
            xsum    <= '0;
          end
        HEADER: begin
          state <= TSTAMP;
          if (full_i) ovf <= 1'b1;
          else begin
            wr_en_o <= 1'b1;
            din_o   <= 64'(ts_lat);
          end
        end
        TSTAMP: begin
          state <= DATA;
          idx   <= '0;
        end
        DATA:
          if (idx == N_WORDS - 16'd1) state <= TRAILER;
          else idx <= idx + 16'd1;
        TRAILER:
          if (!full_i) begin
            wr_en_o       <= 1'b1;
            din_o         <= {TRL_MAGIC, 7'h0, ovf, n_wr, xsum};
            state         <= leave_idle ? IDLE : ARMED;
            pend          <= 1'b0;
            event_count_o <= event_count_o + 32'd1;
          end
        default: state <= IDLE;
      endcase
      if (c_clear) begin
        event_count_o <= '0;
        drop_count_o  <= '0;
        ts            <= '0;
      end
    end
  end
endmodule

// File: tb/tb_event_packer.sv
// tb_event_packer: directed vectors and event sequences checked against hand-derived frames
module tb_event_packer;
  logic        clk = 1'b0;
  logic        aresetn, trigger, cmd_valid_i, full_i;
  logic [63:0] ch_data_i;
  logic [7:0]  cmd;
  logic        wr_en_o, armed_o, busy_o;
  logic [63:0] din_o;
  logic [31:0] event_count_o;
  logic [15:0] drop_count_o;
  int total = 0, bad = 0, cnt = 0, rel_cnt = 0;
  typedef struct { int c; logic [63:0] d; } wr_t;
  wr_t wq[$];
  typedef struct {
    logic v; logic [7:0] c; logic tr; logic fu;
    logic arm; logic bsy; logic [15:0] drp; logic [31:0] evt;
  } vec_t;
  vec_t tbl [11];

  event_packer dut (
    .f125_clk(clk), .aresetn(aresetn), .trigger(trigger), .ch_data_i(ch_data_i),
    .cmd_valid_i(cmd_valid_i), .cmd(cmd), .full_i(full_i), .wr_en_o(wr_en_o),
    .din_o(din_o), .event_count_o(event_count_o), .drop_count_o(drop_count_o),
    .armed_o(armed_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] samp(input int c, input logic [3:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*16 +: 16] = 16'(c + i*4096);
    return r;
  endfunction

  // ch_data_i carries the cycle number on every channel, offset per channel
  always begin
    @(posedge clk);
    #1;
    cnt = cnt + 1;
    ch_data_i = samp(cnt, 4'hF);
  end

  always @(negedge clk) if (wr_en_o) wq.push_back('{cnt, din_o});

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go_to(input int v);
    for (int i = 0; i < 2000 && cnt < v; i++) tick();
    chk("sync", 64'(cnt), 64'(v));
  endtask

  task automatic send(input logic [7:0] c);
    cmd_valid_i = 1'b1;
    cmd = c;
    tick();
    cmd_valid_i = 1'b0;
    cmd = 8'h00;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy_o && i < 300) begin
      tick();
      i++;
    end
    chk("idle_timeout", 64'(busy_o), 64'd0);
    tick();
    tick();
  endtask

  task automatic ev_check(input int t, input logic [31:0] id, input logic [3:0] m,
                          input int s_lo, input int s_hi, input int trl_c);
    int j, n, exp_sz;
    logic [31:0] x;
    logic [63:0] w;
    logic ov;
    n = 0;
    x = '0;
    ov = s_lo <= s_hi;
    exp_sz = 35 - (ov ? s_hi - s_lo + 1 : 0);
    chk($sformatf("ev%0d_nwrites", id), 64'(wq.size()), 64'(exp_sz));
    if (wq.size() != exp_sz) return;
    chk($sformatf("ev%0d_hdr", id), wq[0].d, {8'hA5, 4'h0, m, 16'd32, id});
    chk($sformatf("ev%0d_hdr_cyc", id), 64'(wq[0].c), 64'(t + 1));
    chk($sformatf("ev%0d_tstamp", id), wq[1].d, 64'(t - rel_cnt));
    j = 2;
    for (int k = 0; k < 32; k++) begin
      if (k >= s_lo && k <= s_hi) continue;
      w = samp(t - 8 + k, m);
      chk($sformatf("ev%0d_data%0d", id, k), wq[j].d, w);
      chk($sformatf("ev%0d_data%0d_cyc", id, k), 64'(wq[j].c), 64'(t + 3 + k));
      x ^= w[63:32] ^ w[31:0];
      n++;
      j++;
    end
    chk($sformatf("ev%0d_trailer", id), wq[j].d, {8'h5A, 7'h0, ov, 16'(n), x});
    chk($sformatf("ev%0d_trailer_cyc", id), 64'(wq[j].c), 64'(trl_c));
  endtask

  initial begin
    int t;
    tbl[0]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 32'd4};
    tbl[1]  = '{1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 32'd4};
    tbl[2]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 32'd4};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 32'd4};
    tbl[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 32'd4};
    tbl[5]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 32'd4};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 32'd4};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 32'd4};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 32'd4};
    tbl[9]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0};
    tbl[10] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0};
    aresetn = 1'b0;
    trigger = 1'b0;
    cmd_valid_i = 1'b0;
    cmd = 8'h00;
    full_i = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("rst_din", din_o, 64'd0);
    chk("rst_evt", 64'(event_count_o), 64'd0);
    chk("rst_drop", 64'(drop_count_o), 64'd0);
    chk("rst_armed", 64'(armed_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    aresetn = 1'b1;
    rel_cnt = cnt;
    go_to(20);
    send(8'h01);
    chk("arm", 64'(armed_o), 64'd1);
    // event 0: clean window
    wq.delete();
    go_to(100);
    pulse_trigger();
    chk("ev0_busy", 64'(busy_o), 64'd1);
    wait_idle();
    ev_check(100, 32'd0, 4'hF, 1, 0, 136);
    chk("ev0_count", 64'(event_count_o), 64'd1);
    chk("ev0_drop", 64'(drop_count_o), 64'd0);
    // event 1: retrigger, three full data cycles, trailer held by full
    wq.delete();
    go_to(200);
    pulse_trigger();
    go_to(205);
    pulse_trigger();
    go_to(210);
    full_i = 1'b1;
    go_to(213);
    full_i = 1'b0;
    go_to(234);
    full_i = 1'b1;
    go_to(241);
    full_i = 1'b0;
    wait_idle();
    ev_check(200, 32'd1, 4'hF, 8, 10, 242);
    chk("ev1_count", 64'(event_count_o), 64'd2);
    chk("ev1_drop", 64'(drop_count_o), 64'd1);
    chk("ev1_armed", 64'(armed_o), 64'd1);
    go_to(250);
    send(8'h02);
    chk("disarm_idle", 64'(armed_o), 64'd0);
    // event 2: mask 0x5, with a mask change attempted while busy
    go_to(260);
    send(8'h15);
    send(8'h01);
    wq.delete();
    go_to(300);
    pulse_trigger();
    go_to(310);
    send(8'h1A);
    wait_idle();
    ev_check(300, 32'd2, 4'h5, 1, 0, 336);
    // event 3: disarm deferred until the trailer
    wq.delete();
    go_to(350);
    pulse_trigger();
    go_to(360);
    send(8'h02);
    chk("pend_armed", 64'(armed_o), 64'd0);
    chk("pend_busy", 64'(busy_o), 64'd1);
    wait_idle();
    ev_check(350, 32'd3, 4'h5, 1, 0, 386);
    chk("ev3_armed", 64'(armed_o), 64'd0);
    chk("ev3_count", 64'(event_count_o), 64'd4);
    // command/trigger vectors from IDLE
    wq.delete();
    for (int i = 0; i < 11; i++) begin
      cmd_valid_i = tbl[i].v;
      cmd = tbl[i].c;
      trigger = tbl[i].tr;
      full_i = tbl[i].fu;
      tick();
      chk($sformatf("tbl%0d_armed", i), 64'(armed_o), 64'(tbl[i].arm));
      chk($sformatf("tbl%0d_busy", i), 64'(busy_o), 64'(tbl[i].bsy));
      chk($sformatf("tbl%0d_drop", i), 64'(drop_count_o), 64'(tbl[i].drp));
      chk($sformatf("tbl%0d_evt", i), 64'(event_count_o), 64'(tbl[i].evt));
    end
    cmd_valid_i = 1'b0;
    cmd = 8'h00;
    trigger = 1'b0;
    full_i = 1'b0;
    tick();
    chk("tbl_writes", 64'(wq.size()), 64'd0);
    // reset in the middle of the data phase
    send(8'h01);
    t = cnt + 20;
    go_to(t);
    pulse_trigger();
    go_to(t + 13);
    chk("pre_rst_wr", 64'(wr_en_o), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_wr", 64'(wr_en_o), 64'd0);
    chk("mid_rst_din", din_o, 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    repeat (3) tick();
    aresetn = 1'b1;
    wq.delete();
    repeat (60) tick();
    chk("post_rst_writes", 64'(wq.size()), 64'd0);
    chk("post_rst_armed", 64'(armed_o), 64'd0);
    chk("post_rst_evt", 64'(event_count_o), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
